// File: rtl/encode_pack_if.sv
// Handshake bundle for encode_pack: code input side, packed-word output side, flush control.
// Optional word counter signal present when ENCODE_PACK_WCNT_EN is defined.
interface encode_pack_if #(
  parameter int OUT_W = 16,
  parameter int IN_W  = 13,
  parameter int LEN_W = 4
);
  logic             din_valid_i;
  logic             din_ready_o;
  logic [IN_W-1:0]  din_data_i;
  logic [LEN_W-1:0] din_len_i;
  logic             finish_i;
  logic [OUT_W-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             done_o;
`ifdef ENCODE_PACK_WCNT_EN
  logic [31:0]      word_cnt_o;

  modport master (
    output din_valid_i, din_data_i, din_len_i, finish_i, ready_i,
    input  din_ready_o, data_o, valid_o, done_o, word_cnt_o
  );
  modport slave (
    input  din_valid_i, din_data_i, din_len_i, finish_i, ready_i,
    output din_ready_o, data_o, valid_o, done_o, word_cnt_o
  );
`else
  modport master (
    output din_valid_i, din_data_i, din_len_i, finish_i, ready_i,
    input  din_ready_o, data_o, valid_o, done_o
  );
  modport slave (
    input  din_valid_i, din_data_i, din_len_i, finish_i, ready_i,
    output din_ready_o, data_o, valid_o, done_o
  );
`endif
endinterface

// File: rtl/encode_pack.sv
// Variable-length code packer: MSB-first codes into OUT_W-bit words, zero-padded flush.
// Optional feature macro: ENCODE_PACK_WCNT_EN adds a 32-bit emitted-word counter.
module encode_pack #(
  parameter int OUT_W = 16,
  parameter int IN_W  = 13,
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  encode_pack_if.slave  bus
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam int TOT_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [TOT_W-1:0] fill_r, fill_s;
  logic [OUT_W-1:0] data_r, data_s;
  logic             valid_r, valid_s;
  logic             done_r, done_s;

  logic             slot_free_s;
  logic             accept_s;
  logic [TOT_W-1:0] len_s;
  logic [TOT_W-1:0] tot_s;
  logic [IN_W-1:0]  code_s;
  logic [ACC_W-1:0] acc_sh_s;
  logic [OUT_W-1:0] word_s;
  logic [OUT_W-1:0] flush_word_s;

  assign slot_free_s     = !valid_r || bus.ready_i;
  assign bus.din_ready_o = (state_r == RUN) && slot_free_s;
  assign accept_s        = bus.din_valid_i && bus.din_ready_o;

  // Clamp over-long lengths to IN_W and mask code bits above the length
  always_comb begin
    if (bus.din_len_i > LEN_W'(IN_W)) begin
      len_s = TOT_W'(IN_W);
    end else begin
      len_s = TOT_W'(bus.din_len_i);
    end
    code_s       = bus.din_data_i & ~({IN_W{1'b1}} << len_s);
    tot_s        = fill_r + len_s;
    acc_sh_s     = (acc_r << len_s) | ACC_W'(code_s);
    // Only the low tot_s bits of the accumulator are live; stale bits above are shifted out
    word_s       = OUT_W'(acc_sh_s >> (tot_s - TOT_W'(OUT_W)));
    flush_word_s = OUT_W'(acc_r << (TOT_W'(OUT_W) - fill_r));
  end

  // Next-state, accumulator and output-slot logic
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    fill_s  = fill_r;
    data_s  = data_r;
    valid_s = valid_r && !bus.ready_i;
    done_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (accept_s) begin
          acc_s = acc_sh_s;
          if (tot_s >= TOT_W'(OUT_W)) begin
            data_s  = word_s;
            valid_s = 1'b1;
            fill_s  = tot_s - TOT_W'(OUT_W);
          end else begin
            fill_s  = tot_s;
          end
        end else begin
          fill_s = fill_r;
        end
        if (bus.finish_i) begin
          state_s = FLUSH;
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (fill_r == TOT_W'(0)) begin
          state_s = DRAIN;
        end else if (slot_free_s) begin
          data_s  = flush_word_s;
          valid_s = 1'b1;
          fill_s  = TOT_W'(0);
          state_s = DRAIN;
        end else begin
          state_s = FLUSH;
        end
      end
      DRAIN: begin
        if (!valid_r) begin
          done_s  = 1'b1;
          acc_s   = ACC_W'(0);
          state_s = RUN;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= ACC_W'(0);
      fill_r  <= TOT_W'(0);
      data_r  <= OUT_W'(0);
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      acc_r   <= acc_s;
      fill_r  <= fill_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      done_r  <= done_s;
    end
  end

  assign bus.data_o  = data_r;
  assign bus.valid_o = valid_r;
  assign bus.done_o  = done_r;

`ifdef ENCODE_PACK_WCNT_EN
  logic [31:0] word_cnt_r;

  // Count every accepted output word; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_r <= 32'd0;
    end else if (valid_r && bus.ready_i) begin
      word_cnt_r <= word_cnt_r + 32'd1;
    end else begin
      word_cnt_r <= word_cnt_r;
    end
  end

  assign bus.word_cnt_o = word_cnt_r;
`endif

endmodule

// File: tb/tb_encode_pack.sv
// Self-checking bench for encode_pack: directed cases plus random traffic scored
// against a bit-queue reference model.
module tb_encode_pack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  encode_pack_if #(.OUT_W(16), .IN_W(13), .LEN_W(4)) bus ();

  encode_pack #(.OUT_W(16), .IN_W(13), .LEN_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: stream of code bits, expected words, stream state
  bit          bq[$];
  logic [15:0] exp_q[$];
  logic        run_m = 1'b1;
  int unsigned cnt_m = 0;

  logic        o_valid, o_rdy, o_done;
  logic [15:0] o_data;
  logic        done_seen;
  logic [15:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    exp_q.delete();
    run_m = 1'b1;
    cnt_m = 0;
  endtask

  task automatic model_words();
    logic [15:0] w;
    while (bq.size() >= 16) begin
      w = 16'h0000;
      for (int i = 0; i < 16; i++) w = {w[14:0], bq.pop_front()};
      exp_q.push_back(w);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, score handshakes
  task automatic step(input logic v, input logic [12:0] d, input logic [3:0] l,
                      input logic f, input logic r);
    int le;
    @(negedge clk);
    bus.din_valid_i = v;
    bus.din_data_i  = d;
    bus.din_len_i   = l;
    bus.finish_i    = f;
    bus.ready_i     = r;
    #1;
    o_valid = bus.valid_o;
    o_data  = bus.data_o;
    o_rdy   = bus.din_ready_o;
    o_done  = bus.done_o;
    if (o_done) run_m = 1'b1;
    chk("din_ready", {31'd0, o_rdy}, {31'd0, run_m && (!o_valid || r)});
    if (o_valid) chk("spurious_valid", {31'd0, exp_q.size() != 0}, 32'd1);
`ifdef ENCODE_PACK_WCNT_EN
    chk("word_cnt", bus.word_cnt_o, cnt_m);
`endif
    if (o_valid && r) begin
      if (exp_q.size() != 0) chk("word", {16'd0, o_data}, {16'd0, exp_q.pop_front()});
      cnt_m++;
    end
    if (v && o_rdy) begin
      le = (l > 4'd13) ? 13 : int'(l);
      for (int i = le - 1; i >= 0; i--) bq.push_back(d[i]);
      model_words();
    end
    if (f && run_m) begin
      if (bq.size() > 0) begin
        while (bq.size() < 16) bq.push_back(1'b0);
        model_words();
      end
      run_m = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    done_seen = 1'b0;
    for (int i = 0; i < 12 && !done_seen; i++) begin
      step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
      if (o_done) done_seen = 1'b1;
    end
    chk(tag, {31'd0, done_seen}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        v, f, r;
    logic [12:0] d;
    logic [3:0]  l;

    bus.din_valid_i = 1'b0;
    bus.din_data_i  = 13'h0000;
    bus.din_len_i   = 4'd0;
    bus.finish_i    = 1'b0;
    bus.ready_i     = 1'b1;
    #1;
    chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("rst_data", {16'd0, bus.data_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
`ifdef ENCODE_PACK_WCNT_EN
    chk("rst_wcnt", bus.word_cnt_o, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Four nibbles with garbage above the length -> 0xABCD one cycle after last accept
    step(1'b1, 13'h1F5A, 4'd4, 1'b0, 1'b1);
    step(1'b1, 13'h0FEB, 4'd4, 1'b0, 1'b1);
    step(1'b1, 13'h000C, 4'd4, 1'b0, 1'b1);
    step(1'b1, 13'h1ABD, 4'd4, 1'b0, 1'b1);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t1_valid", {31'd0, o_valid}, 32'd1);
    chk("t1_word", {16'd0, o_data}, 32'h0000ABCD);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t1_valid_drop", {31'd0, o_valid}, 32'd0);

    // 13 ones then 7-bit 0x55 -> 0xFFFD, residual 0101 flushed as 0x5000
    step(1'b1, 13'h1FFF, 4'd13, 1'b0, 1'b1);
    step(1'b1, 13'h0055, 4'd7, 1'b0, 1'b1);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t2_word", {16'd0, o_data}, 32'h0000FFFD);
    step(1'b0, 13'h0000, 4'd0, 1'b1, 1'b1);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t3_valid", {31'd0, o_valid}, 32'd1);
    chk("t3_flush_word", {16'd0, o_data}, 32'h00005000);
    wait_done("t3_done");
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t3_done_pulse", {31'd0, o_done}, 32'd0);

    // Backpressure: word held stable for 5 cycles, input blocked
    step(1'b1, 13'h1ABC, 4'd13, 1'b0, 1'b0);
    step(1'b1, 13'h001F, 4'd5, 1'b0, 1'b0);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 13'($urandom), 4'($urandom_range(1, 13)), 1'b0, 1'b0);
      chk("t4_hold_valid", {31'd0, o_valid}, 32'd1);
      chk("t4_hold_data", {16'd0, o_data}, {16'd0, held});
      chk("t4_hold_block", {31'd0, o_rdy}, 32'd0);
    end

    // Random traffic against the bit-queue model, including over-long lengths
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 13'($urandom);
      l = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 3) != 0);
      step(v, d, l, 1'b0, r);
    end
    step(1'b0, 13'h0000, 4'd0, 1'b1, 1'b1);
    wait_done("rand_done");
    chk("rand_all_words", exp_q.size(), 32'd0);

    // Empty flush: zero-length beats with garbage, then finish -> no word, quick done
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 13'h1FFF, 4'd0, 1'b0, 1'b1);
      chk("t5_no_valid", {31'd0, o_valid}, 32'd0);
    end
    step(1'b0, 13'h0000, 4'd0, 1'b1, 1'b1);
    done_seen = 1'b0;
    for (int i = 0; i < 4 && !done_seen; i++) begin
      step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
      chk("t5_no_valid_flush", {31'd0, o_valid}, 32'd0);
      if (o_done) done_seen = 1'b1;
    end
    chk("t5_done", {31'd0, done_seen}, 32'd1);

    // Reset mid-word with a pending output, then a fresh stream
    step(1'b1, 13'h0123, 4'd13, 1'b0, 1'b0);
    step(1'b1, 13'h0ABC, 4'd12, 1'b0, 1'b0);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b0);
    chk("t6_pending", {31'd0, o_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    chk("t6_rst_data", {16'd0, bus.data_o}, 32'd0);
    chk("t6_rst_done", {31'd0, bus.done_o}, 32'd0);
`ifdef ENCODE_PACK_WCNT_EN
    chk("t6_rst_wcnt", bus.word_cnt_o, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 13'h0001, 4'd4, 1'b0, 1'b1);
    step(1'b1, 13'h0002, 4'd4, 1'b0, 1'b1);
    step(1'b1, 13'h0003, 4'd4, 1'b0, 1'b1);
    step(1'b1, 13'h0004, 4'd4, 1'b0, 1'b1);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t6_word", {16'd0, o_data}, 32'h00001234);
    step(1'b0, 13'h0000, 4'd0, 1'b0, 1'b1);
    chk("t6_all_words", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
